hs32_mem_ctrl: RTL and testbench
================================

// Module: hs32_mem_ctrl
// PURPOSE
//  Shared-SRAM controller between the Caravel Wishbone slave port and the HS32 core memory port.
//  The management SoC loads program/data words over Wishbone while the core is held in reset.
//  It then sets the run bit, and the core executes its MOV/LDR/STR traffic against the same SRAM.
//  Sits in the user project wrapper: Wishbone and core are upstream, OpenRAM-style macro downstream.
// PARAMETERS
//  AW   10   SRAM word-address width (2**AW 32-bit words)
// PORTS
//  wb_clk_i       in   1   single clock for the whole block
//  wb_rst_i       in   1   reset, asynchronous, active-high
//  wbs_stb_i      in   1   WB strobe
//  wbs_cyc_i      in   1   WB cycle
//  wbs_we_i       in   1   WB write enable
//  wbs_sel_i      in   4   WB byte selects
//  wbs_adr_i      in   32  WB byte address
//  wbs_dat_i      in   32  WB write data
//  wbs_ack_o      out  1   WB ack, one-cycle pulse
//  wbs_dat_o      out  32  WB read data, valid with ack
//  core_stb_i     in   1   core request, held until core_ack_o
//  core_rw_i      in   1   1=write, 0=read
//  core_addr_i    in   32  core byte address
//  core_dtw_i     in   32  core write data
//  core_ack_o     out  1   core ack, one-cycle pulse
//  core_dtr_o     out  32  core read data, valid with ack
//  core_reset_o   out  1   core reset = ~run
//  ram_csb_o      out  1   SRAM chip select, active-low
//  ram_web_o      out  1   SRAM write enable, active-low
//  ram_wmask_o    out  4   SRAM byte mask
//  ram_addr_o     out  AW  SRAM word address
//  ram_din_o      out  32  SRAM write data
//  ram_dout_i     in   32  SRAM read data, valid one edge after the sampling edge
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, ram_csb_o=1, ram_web_o=1, all acks 0, data outputs 0
//   - run=0, core_reset_o=1, last_grant=CORE (so WB wins the first tie)
//  Address decode:
//   - wbs_adr_i[AW+2]=0 selects SRAM word wbs_adr_i[AW+1:2]
//   - wbs_adr_i[AW+2]=1 selects CTRL register: bit0=run, bits[31:1] read 0
//   - Core always targets SRAM at core_addr_i[AW+1:2]; upper bits alias; low 2 bits ignored
//  Requests:
//   - WB request valid = wbs_cyc_i & wbs_stb_i
//   - Core request valid = core_stb_i & run; ignored while core_reset_o=1
//  FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE
//   - IDLE:
//     - If both requests are valid, grant the source not granted last (round-robin); else grant the single requester.
//     - Register ram_addr/din/wmask/web from the winner (WB: wmask=wbs_sel_i; core: wmask=4'hF). Go to ISSUE.
//     - A WB CTRL access skips the SRAM: writes take run<=wbs_dat_i[0] only if wbs_sel_i[0]. Go straight to ACK.
//   - ISSUE: ram_csb_o=0 for exactly one cycle. -> WAIT
//   - WAIT: ram_csb_o=1; capture ram_dout_i into the winner's data register at the end of the cycle. -> ACK
//   - ACK: pulse the winner's ack for exactly one cycle. -> IDLE
//     - Write acks return data 0; read acks return the captured word.
//  Latency, request at IDLE to ack:
//   - SRAM access: 4 cycles; ack is high in the 4th cycle
//   - CTRL access: 2 cycles
//   - Throughput: one access per 4 cycles
//  Ordering and ack rules:
//   - The losing request stays pending and is served next, so there is no starvation.
//   - A request dropped by its master before ack is still completed internally; no stray ack is issued to a dropped WB request.
//   - run cleared while a core access is in flight: that access still completes and acks; core_reset_o rises immediately.
//  ram_* outputs hold their last value outside ISSUE; only csb qualifies them.
//  Reset mid-access aborts the access immediately. No ack is issued and SRAM content is undefined for that word only.
// STRUCTURE
//  - Shared header hs32_mem_defs.vh:
//    - FSM state encodings (2-bit)
//    - CTRL offset bit index
//    - Grant encodings GNT_WB=0, GNT_CORE=1
//  - Sub-module hs32_mem_arb: 2-requester round-robin arbiter holding last_grant, one-hot grant out, advances only on accept.
//  - Top holds the FSM, request/data registers and the CTRL register.
// TESTING
//  1. Reset released, no traffic -> core_reset_o=1, ram_csb_o=1, no acks, and core_stb_i=1 is never acked.
//  2. WB write 0x0000CAFE to word 0, sel=4'hF; WB read word 0
//     -> ack 4 cycles after stb, read returns 0x0000CAFE; csb is low for exactly 1 cycle per access.
//  3. WB write 0xAABBCCDD to word 1 with sel=4'b0101 over 0x11111111
//     -> word 1 reads back 0x11BB11DD.
//  4. WB write CTRL=1 -> ack in 2 cycles, core_reset_o falls.
//     Then core reads word 0 -> core_dtr_o=0x0000CAFE with core_ack_o.
//  5. WB and core both request in the same IDLE cycle, back to back for 4 pairs
//     -> grants alternate WB, CORE, WB, CORE; each requester gets one ack per 8 cycles.
//  6. Assert wb_rst_i during the WAIT of a core read
//     -> outputs return to reset values asynchronously, no ack, and run=0 afterwards.

Source files
------------

// File: rtl/hs32_mem_ctrl_pkg.sv
// Shared definitions for the HS32 shared-SRAM controller: FSM states, grant indices,
// and the address bit that selects the CTRL register.
package hs32_mem_ctrl_pkg;

  localparam int AW_DEFAULT = 10;

  localparam int GNT_WB   = 0;
  localparam int GNT_CORE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } mem_state_t;

  // The CTRL register sits just above the SRAM byte-address window.
  function automatic int ctrl_bit(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/hs32_mem_arb.sv
// Two-requester round-robin arbiter (Wishbone vs core). The last grant flips only
// when the controller actually accepts a request.
import hs32_mem_ctrl_pkg::*;

module hs32_mem_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_wb,
  input  logic       req_core,
  input  logic       accept,
  output logic [1:0] grant
);

  // Reset to "core granted last" so Wishbone wins the first tie.
  logic last_core_q;

  always_comb begin
    grant           = '0;
    grant[GNT_WB]   = req_wb & (~req_core | last_core_q);
    grant[GNT_CORE] = req_core & (~req_wb | ~last_core_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_core_q <= 1'b1;
    end else if (accept) begin
      last_core_q <= grant[GNT_CORE];
    end
  end

endmodule

// File: rtl/hs32_mem_ctrl.sv
// Shared-SRAM controller: arbitrates Wishbone and HS32 core accesses onto one
// single-port SRAM macro and owns the CTRL run bit that holds the core in reset.
//
// state    | meaning
// IDLE     | waiting for a request; latch winner's address/data/mask
// ISSUE    | chip select asserted for one cycle
// WAIT     | SRAM read data arrives; capture into winner's data register
// ACK      | one-cycle ack pulse to the winner
import hs32_mem_ctrl_pkg::*;

module hs32_mem_ctrl #(
  parameter int AW = AW_DEFAULT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          core_stb_i,
  input  logic          core_rw_i,
  input  logic [31:0]   core_addr_i,
  input  logic [31:0]   core_dtw_i,
  output logic          core_ack_o,
  output logic [31:0]   core_dtr_o,
  output logic          core_reset_o,
  output logic          ram_csb_o,
  output logic          ram_web_o,
  output logic [3:0]    ram_wmask_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_din_o,
  input  logic [31:0]   ram_dout_i
);

  localparam int CTRL_BIT = ctrl_bit(AW);

  mem_state_t state_q, state_nxt;

  logic          wb_req, core_req, wb_ctrl, accept;
  logic [1:0]    grant;
  logic          run_q, sel_core_q, wb_live_q, ram_web_q;
  logic [3:0]    ram_wmask_q;
  logic [AW-1:0] ram_addr_q;
  logic [31:0]   ram_din_q, wb_dat_q, core_dtr_q;
  logic          unused_addr;

  assign wb_req   = wbs_cyc_i & wbs_stb_i;
  assign core_req = core_stb_i & run_q;
  assign wb_ctrl  = wbs_adr_i[CTRL_BIT];
  assign accept   = (state_q == ST_IDLE) & (wb_req | core_req);

  assign unused_addr = ^{wbs_adr_i[31:CTRL_BIT+1], wbs_adr_i[1:0],
                         core_addr_i[31:AW+2], core_addr_i[1:0]};

  hs32_mem_arb u_arb (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .req_wb   (wb_req),
    .req_core (core_req),
    .accept   (accept),
    .grant    (grant)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_nxt = (grant[GNT_WB] & wb_ctrl) ? ST_ACK : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_ACK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      run_q       <= 1'b0;
      sel_core_q  <= 1'b0;
      wb_live_q   <= 1'b0;
      ram_web_q   <= 1'b1;
      ram_wmask_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      wb_dat_q    <= '0;
      core_dtr_q  <= '0;
    end else begin
      if (accept) begin
        if (grant[GNT_CORE]) begin
          sel_core_q  <= 1'b1;
          ram_web_q   <= ~core_rw_i;
          ram_wmask_q <= 4'hF;
          ram_addr_q  <= core_addr_i[AW+1:2];
          ram_din_q   <= core_dtw_i;
        end else begin
          sel_core_q <= 1'b0;
          wb_live_q  <= 1'b1;
          if (wb_ctrl) begin
            // CTRL bypasses the SRAM entirely; only byte lane 0 carries run.
            if (wbs_we_i && wbs_sel_i[0]) run_q <= wbs_dat_i[0];
            wb_dat_q <= wbs_we_i ? '0 : {31'b0, run_q};
          end else begin
            ram_web_q   <= ~wbs_we_i;
            ram_wmask_q <= wbs_sel_i;
            ram_addr_q  <= wbs_adr_i[AW+1:2];
            ram_din_q   <= wbs_dat_i;
          end
        end
      end else if (state_q != ST_IDLE && !wb_req) begin
        // A master that walks away mid-access must not see a late ack.
        wb_live_q <= 1'b0;
      end

      if (state_q == ST_WAIT) begin
        if (sel_core_q) core_dtr_q <= ram_web_q ? ram_dout_i : '0;
        else            wb_dat_q   <= ram_web_q ? ram_dout_i : '0;
      end
    end
  end

  assign ram_csb_o    = (state_q != ST_ISSUE);
  assign ram_web_o    = ram_web_q;
  assign ram_wmask_o  = ram_wmask_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_din_o    = ram_din_q;
  assign wbs_ack_o    = (state_q == ST_ACK) & ~sel_core_q & wb_live_q & wb_req;
  assign wbs_dat_o    = wb_dat_q;
  assign core_ack_o   = (state_q == ST_ACK) & sel_core_q;
  assign core_dtr_o   = core_dtr_q;
  assign core_reset_o = ~run_q;

endmodule

// File: tb/tb_hs32_mem_ctrl.sv
// Bench for hs32_mem_ctrl: directed scenarios plus randomized two-master traffic,
// checked every cycle against a transaction-level model of the controller.
`timescale 1ns/1ps
module tb_hs32_mem_ctrl;
  localparam int AW = 10;
  localparam logic [31:0] CTRL_ADR = 32'h1 << (AW + 2);

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          core_stb_i, core_rw_i;
  logic [31:0]   core_addr_i, core_dtw_i;
  logic          core_ack_o;
  logic [31:0]   core_dtr_o;
  logic          core_reset_o;
  logic          ram_csb_o, ram_web_o;
  logic [3:0]    ram_wmask_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_din_o;
  logic [31:0]   ram_dout_i;

  always #5 wb_clk_i = ~wb_clk_i;

  hs32_mem_ctrl #(.AW(AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_stb_i(core_stb_i), .core_rw_i(core_rw_i), .core_addr_i(core_addr_i),
    .core_dtw_i(core_dtw_i), .core_ack_o(core_ack_o), .core_dtr_o(core_dtr_o),
    .core_reset_o(core_reset_o),
    .ram_csb_o(ram_csb_o), .ram_web_o(ram_web_o), .ram_wmask_o(ram_wmask_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: samples on the edge with csb low, read data valid after that edge.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge wb_clk_i) begin
    if (!ram_csb_o) begin
      if (!ram_web_o)
        for (int b = 0; b < 4; b++)
          if (ram_wmask_o[b]) sram[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
      ram_dout_i <= sram[ram_addr_o];
    end
  end

  // ---------------- transaction-level reference model ----------------
  int           cyc = 0;
  bit           mdl_en = 0;
  bit           m_run, m_last_core, wb_ok, ex_core, m_wb, m_core;
  int           free_at, acc_cyc, issue_cyc, ack_cyc;
  logic [31:0]  ex_dat, ex_din;
  logic [AW-1:0] ex_addr;
  logic [3:0]   ex_mask;
  logic         ex_web;
  logic [31:0]  mdl_mem [0:(1<<AW)-1];
  bit           log_en = 0;
  int           log_who[$];
  int           log_wb_cyc[$];
  int           log_core_cyc[$];

  task automatic mdl_reset();
    m_run = 0; m_last_core = 1; free_at = 0;
    issue_cyc = -1; ack_cyc = -1; acc_cyc = -1; wb_ok = 0; ex_core = 0;
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  always @(negedge wb_clk_i) begin
    cyc++;
    if (mdl_en && !wb_rst_i) begin
      if (!ex_core && cyc > acc_cyc && cyc <= ack_cyc) wb_ok = wb_ok & wbs_cyc_i & wbs_stb_i;
      chk("csb", 32'(ram_csb_o), 32'((cyc == issue_cyc) ? 0 : 1));
      if (cyc == issue_cyc) begin
        chk("ram_addr", 32'(ram_addr_o), 32'(ex_addr));
        chk("ram_web", 32'(ram_web_o), 32'(ex_web));
        if (!ex_web) begin
          chk("ram_wmask", 32'(ram_wmask_o), 32'(ex_mask));
          chk("ram_din", ram_din_o, ex_din);
        end
      end
      chk("wb_ack", 32'(wbs_ack_o), 32'(cyc == ack_cyc && !ex_core && wb_ok));
      chk("core_ack", 32'(core_ack_o), 32'(cyc == ack_cyc && ex_core));
      if (cyc == ack_cyc && !ex_core && wb_ok) chk("wb_dat", wbs_dat_o, ex_dat);
      if (cyc == ack_cyc && ex_core) chk("core_dtr", core_dtr_o, ex_dat);
      chk("core_reset", 32'(core_reset_o), 32'(!m_run));

      if (log_en && wbs_ack_o) begin log_who.push_back(0); log_wb_cyc.push_back(cyc); end
      if (log_en && core_ack_o) begin log_who.push_back(1); log_core_cyc.push_back(cyc); end

      m_wb   = wbs_cyc_i & wbs_stb_i;
      m_core = core_stb_i & m_run;
      if (cyc >= free_at && (m_wb || m_core)) begin
        ex_core = m_core && (!m_wb || !m_last_core);
        m_last_core = ex_core;
        acc_cyc = cyc;
        if (ex_core) begin
          ex_addr = core_addr_i[AW+1:2]; ex_web = !core_rw_i; ex_mask = 4'hF; ex_din = core_dtw_i;
        end else begin
          wb_ok = 1;
          ex_addr = wbs_adr_i[AW+1:2]; ex_web = !wbs_we_i; ex_mask = wbs_sel_i; ex_din = wbs_dat_i;
        end
        if (!ex_core && wbs_adr_i[AW+2]) begin
          ex_dat = wbs_we_i ? 32'h0 : {31'h0, m_run};
          if (wbs_we_i && wbs_sel_i[0]) m_run = wbs_dat_i[0];
          issue_cyc = -1; ack_cyc = cyc + 1; free_at = cyc + 2;
        end else begin
          ex_dat = ex_web ? mdl_mem[ex_addr] : 32'h0;
          if (!ex_web) mdl_mem[ex_addr] = merge_bytes(mdl_mem[ex_addr], ex_din, ex_mask);
          issue_cyc = cyc + 1; ack_cyc = cyc + 3; free_at = cyc + 4;
        end
      end
    end
  end

  // ---------------- master tasks ----------------
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat,
                         output int csb_lo);
    bit got;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0; csb_lo = 0; rd = '0; got = 0;
    while (!got && lat < 24) begin
      @(negedge wb_clk_i);
      lat++;
      if (!ram_csb_o) csb_lo++;
      if (wbs_ack_o) begin got = 1; rd = wbs_dat_o; end
    end
    chk("wb_ack_seen", 32'(got), 32'd1);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic core_xfer(input bit rw, input logic [31:0] adr, input logic [31:0] dat,
                           input int tmo, output logic [31:0] rd, output int lat, output bit got);
    @(posedge wb_clk_i); #1;
    core_stb_i = 1; core_rw_i = rw; core_addr_i = adr; core_dtw_i = dat;
    lat = 0; rd = '0; got = 0;
    while (!got && lat < tmo) begin
      @(negedge wb_clk_i);
      lat++;
      if (core_ack_o) begin got = 1; rd = core_dtr_o; end
    end
    @(posedge wb_clk_i); #1;
    core_stb_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int lat, lo, n;
    bit got;

    for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = 32'h0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    core_stb_i = 0; core_rw_i = 0; core_addr_i = 0; core_dtw_i = 0;
    mdl_reset();
    wb_rst_i = 1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_csb", 32'(ram_csb_o), 32'd1);
    chk("rst_web", 32'(ram_web_o), 32'd1);
    chk("rst_acks", 32'({wbs_ack_o, core_ack_o}), 32'd0);
    chk("rst_core_reset", 32'(core_reset_o), 32'd1);
    chk("rst_data", wbs_dat_o | core_dtr_o, 32'd0);
    wb_rst_i = 0;
    mdl_en = 1;

    // 1: core is held in reset, its request is never served
    core_stb_i = 1; core_rw_i = 0; core_addr_i = 32'h4;
    n = 0; lo = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (core_ack_o || wbs_ack_o) n++;
      if (!ram_csb_o) lo++;
    end
    chk("t1_no_ack", 32'(n), 32'd0);
    chk("t1_no_csb", 32'(lo), 32'd0);
    chk("t1_core_reset", 32'(core_reset_o), 32'd1);
    @(posedge wb_clk_i); #1; core_stb_i = 0;

    // 2: WB write and read back word 0
    wb_xfer(1, 32'h0, 32'h0000CAFE, 4'hF, rd, lat, lo);
    chk("t2_wr_lat", 32'(lat), 32'd4);
    chk("t2_wr_csb_lo", 32'(lo), 32'd1);
    chk("t2_wr_dat", rd, 32'h0);
    wb_xfer(0, 32'h0, 32'h0, 4'hF, rd, lat, lo);
    chk("t2_rd_lat", 32'(lat), 32'd4);
    chk("t2_rd_csb_lo", 32'(lo), 32'd1);
    chk("t2_rd_dat", rd, 32'h0000CAFE);

    // preload words 1..15 with known values
    for (int i = 1; i < 16; i++)
      wb_xfer(1, 32'(i * 4), (i == 1) ? 32'h11111111 : (32'hA5000000 | 32'(i)), 4'hF, rd, lat, lo);

    // 3: byte-masked write
    wb_xfer(1, 32'h4, 32'hAABBCCDD, 4'b0101, rd, lat, lo);
    wb_xfer(0, 32'h4, 32'h0, 4'hF, rd, lat, lo);
    chk("t3_masked", rd, 32'h11BB11DD);

    // 4: CTRL run bit, then core read
    wb_xfer(1, CTRL_ADR, 32'h1, 4'h1, rd, lat, lo);
    chk("t4_ctrl_lat", 32'(lat), 32'd2);
    chk("t4_ctrl_csb", 32'(lo), 32'd0);
    chk("t4_core_reset", 32'(core_reset_o), 32'd0);
    wb_xfer(0, CTRL_ADR, 32'h0, 4'hF, rd, lat, lo);
    chk("t4_ctrl_rd", rd, 32'h1);
    core_xfer(0, 32'hFFFF_F000, 32'h0, 20, rd, lat, got);
    chk("t4_core_got", 32'(got), 32'd1);
    chk("t4_core_lat", 32'(lat), 32'd4);
    chk("t4_core_dtr", rd, 32'h0000CAFE);

    // 5: simultaneous requests alternate
    log_who.delete(); log_wb_cyc.delete(); log_core_cyc.delete();
    log_en = 1;
    fork
      begin
        logic [31:0] r5; int l5, c5;
        for (int i = 0; i < 4; i++) wb_xfer(0, 32'((4 + i) * 4), 32'h0, 4'hF, r5, l5, c5);
      end
      begin
        logic [31:0] r6; int l6; bit g6;
        for (int i = 0; i < 4; i++) core_xfer(0, 32'((8 + i) * 4), 32'h0, 20, r6, l6, g6);
      end
    join
    log_en = 0;
    chk("t5_count", 32'(log_who.size()), 32'd8);
    for (int i = 0; i < log_who.size() && i < 8; i++) chk("t5_order", 32'(log_who[i]), 32'(i % 2));
    for (int i = 1; i < log_wb_cyc.size(); i++)
      chk("t5_wb_period", 32'(log_wb_cyc[i] - log_wb_cyc[i-1]), 32'd8);
    for (int i = 1; i < log_core_cyc.size(); i++)
      chk("t5_core_period", 32'(log_core_cyc[i] - log_core_cyc[i-1]), 32'd8);

    // randomized two-master traffic
    fork
      begin
        logic [31:0] r7; int l7, c7;
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
          if ($urandom_range(0, 7) == 0)
            wb_xfer($urandom_range(0, 3) != 0, CTRL_ADR,
                    32'($urandom_range(0, 3) != 0) | ($urandom() & 32'hFFFF_FFFE),
                    4'($urandom_range(0, 15)), r7, l7, c7);
          else
            wb_xfer($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3)),
                    $urandom(), 4'($urandom_range(0, 15)), r7, l7, c7);
        end
      end
      begin
        logic [31:0] r8; int l8; bit g8;
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
          core_xfer($urandom_range(0, 1) == 1,
                    ($urandom() & 32'hFFFF_F003) | 32'($urandom_range(0, 15) * 4),
                    $urandom(), 30, r8, l8, g8);
        end
      end
    join
    repeat (6) @(posedge wb_clk_i);

    // dropped WB request is completed silently
    #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    n = 0;
    repeat (6) begin @(negedge wb_clk_i); if (wbs_ack_o) n++; end
    chk("drop_no_ack", 32'(n), 32'd0);

    // 6: reset during WAIT of a core read
    wb_xfer(1, CTRL_ADR, 32'h1, 4'h1, rd, lat, lo);
    @(posedge wb_clk_i); #1;
    core_stb_i = 1; core_rw_i = 0; core_addr_i = 32'h0;
    n = 0;
    while (ram_csb_o && n < 10) begin @(negedge wb_clk_i); n++; end
    chk("t6_issue_seen", 32'(ram_csb_o), 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1;
    #1;
    chk("t6_csb", 32'(ram_csb_o), 32'd1);
    chk("t6_web", 32'(ram_web_o), 32'd1);
    chk("t6_acks", 32'({wbs_ack_o, core_ack_o}), 32'd0);
    chk("t6_core_reset", 32'(core_reset_o), 32'd1);
    chk("t6_data", wbs_dat_o | core_dtr_o, 32'd0);
    mdl_en = 0;
    mdl_reset();
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 0;
    mdl_en = 1;
    n = 0;
    repeat (8) begin @(negedge wb_clk_i); if (core_ack_o) n++; end
    chk("t6_no_ack_after", 32'(n), 32'd0);
    chk("t6_run_cleared", 32'(core_reset_o), 32'd1);
    core_stb_i = 0;
    repeat (2) @(posedge wb_clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
